// File: rtl/boot_loader.sv
// boot_loader: copies PROG_LEN words from the boot ROM into RAM after reset,
// then raises boot_done so the CPU may take over the bus. A reboot_i pulse
// while done repeats the copy without a full reset.
//
// Optional feature: define BOOT_CHECKSUM_EN to accumulate a modulo-2^WORD_SIZE
// sum of the copied words and compare it with ROM[PROG_LEN] in a one-cycle
// CHECK state. A mismatch sets boot_err_o until the next reboot or reset.
//
// Ports:
//   clk_i        system clock, rising-edge active
//   rst_ni       asynchronous active-low reset
//   reboot_i     single-cycle copy request, honoured only in DONE
//   rom_addr_o   ROM read address (ROM is combinational)
//   rom_data_i   ROM read data
//   ram_addr_o   RAM write address
//   ram_wdata_o  RAM write data
//   ram_wr_en_o  RAM write strobe
//   boot_done_o  copy (and check) complete; CPU owns the bus
//   boot_busy_o  copy in progress (READ/WRITE/CHECK), registered
//   boot_err_o   checksum mismatch flag (0 when checksum is not built)
//
// state  | meaning
// -------+-------------------------------------------------
// READ   | present idx to ROM, capture word
// WRITE  | write captured word to RAM[idx], advance idx
// CHECK  | compare ROM[PROG_LEN] with running sum (optional)
// DONE   | bus released, wait for reboot_i

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module boot_loader #(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int ADDR_SIZE = `ADDR_SIZE,
  parameter int PROG_LEN  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reboot_i,
  output logic [ADDR_SIZE-1:0] rom_addr_o,
  input  logic [WORD_SIZE-1:0] rom_data_i,
  output logic [ADDR_SIZE-1:0] ram_addr_o,
  output logic [WORD_SIZE-1:0] ram_wdata_o,
  output logic                 ram_wr_en_o,
  output logic                 boot_done_o,
  output logic                 boot_busy_o,
  output logic                 boot_err_o
);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_WRITE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_SIZE-1:0] LAST_IDX  = ADDR_SIZE'(PROG_LEN - 1);
  localparam logic [ADDR_SIZE-1:0] SUM_ADDR  = ADDR_SIZE'(PROG_LEN);

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   idx_q, idx_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;
  // Last written address/data, so the RAM bus holds steady between writes.
  logic [ADDR_SIZE-1:0]   hold_addr_q, hold_addr_d;
  logic [WORD_SIZE-1:0]   hold_data_q, hold_data_d;
  logic                   busy_q, busy_d;
`ifdef BOOT_CHECKSUM_EN
  logic [WORD_SIZE-1:0]   sum_q, sum_d;
  logic                   err_q, err_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_READ;
      idx_q       <= '0;
      data_q      <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      busy_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      busy_q      <= busy_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
`endif
    rom_addr_o  = idx_q;
    ram_addr_o  = hold_addr_q;
    ram_wdata_o = hold_data_q;
    ram_wr_en_o = 1'b0;
    boot_done_o = 1'b0;

    case (state_q)
      S_READ: begin
        data_d  = rom_data_i;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = sum_q + rom_data_i;
`endif
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ram_addr_o  = idx_q;
        ram_wdata_o = data_q;
        ram_wr_en_o = 1'b1;
        hold_addr_d = idx_q;
        hold_data_d = data_q;
        if (idx_q == LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + ADDR_SIZE'(1);
          state_d = S_READ;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: begin
        rom_addr_o = SUM_ADDR;
        if (rom_data_i != sum_q) err_d = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        rom_addr_o  = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        boot_done_o = 1'b1;
        if (reboot_i) begin
          idx_d   = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
          state_d = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase

    // Registered from the next state so busy and done never overlap.
    busy_d = (state_d != S_DONE);
  end

  assign boot_busy_o = busy_q;
`ifdef BOOT_CHECKSUM_EN
  assign boot_err_o = err_q;
`else
  assign boot_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

`ifdef BOOT_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic       clk, rst_n, reboot;
  logic [7:0] rom_addr [2];
  logic [7:0] rom_data [2];
  logic [7:0] ram_addr [2];
  logic [7:0] ram_wdata[2];
  logic       ram_wr_en[2];
  logic       boot_done[2];
  logic       boot_busy[2];
  logic       boot_err [2];

  logic [7:0] rom[2][256];
  logic [7:0] ram[2][256];
  int         wr_cnt[2];

  int errors = 0;
  int checks = 0;

  boot_loader #(.WORD_SIZE(8), .ADDR_SIZE(8), .PROG_LEN(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .reboot_i(reboot),
    .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0]),
    .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]), .ram_wr_en_o(ram_wr_en[0]),
    .boot_done_o(boot_done[0]), .boot_busy_o(boot_busy[0]), .boot_err_o(boot_err[0]));

  boot_loader #(.WORD_SIZE(8), .ADDR_SIZE(8), .PROG_LEN(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .reboot_i(reboot),
    .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1]),
    .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]), .ram_wr_en_o(ram_wr_en[1]),
    .boot_done_o(boot_done[1]), .boot_busy_o(boot_busy[1]), .boot_err_o(boot_err[1]));

  assign rom_data[0] = rom[0][rom_addr[0]];
  assign rom_data[1] = rom[1][rom_addr[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int plen(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Edges from start (reset release or reboot edge) until boot_done is high.
  function automatic int dlat(input int d);
    return 2 * plen(d) + (CKS ? 1 : 0);
  endfunction

  function automatic logic [7:0] csum(input int d);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < plen(d); i++) s = s + rom[d][i];
    return s;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // RAM behind each DUT.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (ram_wr_en[d] === 1'b1) begin
        ram[d][ram_addr[d]] <= ram_wdata[d];
        wr_cnt[d]           <= wr_cnt[d] + 1;
      end
  end

  // Behavioural model: t = edges since the copy started, saturating at done.
  int t[2];
  bit fresh[2];
  bit err_e[2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        t[d] = 0; fresh[d] = 1'b1; err_e[d] = 1'b0;
      end else if (t[d] >= dlat(d)) begin
        if (reboot) begin
          t[d] = 0; fresh[d] = 1'b0; err_e[d] = 1'b0;
        end
      end else begin
        if (CKS && t[d] == 2 * plen(d) && csum(d) != rom[d][plen(d)]) err_e[d] = 1'b1;
        t[d]++;
      end
    end
  end

  logic [7:0] prev_ra[2];
  logic [7:0] prev_rd[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("rst_rom_addr", d, rom_addr[d], 0);
        chk("rst_ram_addr", d, ram_addr[d], 0);
        chk("rst_ram_wdata", d, ram_wdata[d], 0);
        chk("rst_wr_en", d, ram_wr_en[d], 0);
        chk("rst_done", d, boot_done[d], 0);
        chk("rst_busy", d, boot_busy[d], 0);
        chk("rst_err", d, boot_err[d], 0);
      end else begin
        int  n, tt, w;
        bit  done_e, busy_e, wr_e;
        n      = plen(d);
        tt     = t[d];
        done_e = (tt >= dlat(d));
        busy_e = !done_e && !(tt == 0 && fresh[d]);
        wr_e   = (tt < 2 * n) && (tt % 2 == 1);
        chk("done", d, boot_done[d], done_e);
        chk("busy", d, boot_busy[d], busy_e);
        chk("wr_en", d, ram_wr_en[d], wr_e);
        chk("err", d, boot_err[d], err_e[d]);
        if (wr_e) begin
          w = (tt - 1) / 2;
          chk("ram_addr", d, ram_addr[d], w);
          chk("ram_wdata", d, ram_wdata[d], rom[d][w]);
          chk("wr_addr_prev", d, ram_addr[d], prev_ra[d]);
          chk("wr_data_prev", d, ram_wdata[d], prev_rd[d]);
        end else if (done_e) begin
          chk("done_rom_addr", d, rom_addr[d], 0);
          chk("done_ram_addr", d, ram_addr[d], 0);
          chk("done_ram_wdata", d, ram_wdata[d], 0);
        end else if (tt < 2 * n) begin
          chk("read_rom_addr", d, rom_addr[d], tt / 2);
        end else begin
          chk("check_rom_addr", d, rom_addr[d], n);
        end
      end
      prev_ra[d] = rom_addr[d];
      prev_rd[d] = rom_data[d];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Counts edges until each DUT shows boot_done; -1 if the budget expires.
  task automatic wait_done(output int ea, output int eb);
    ea = -1; eb = -1;
    for (int e = 1; e <= 60 && (ea < 0 || eb < 0); e++) begin
      @(negedge clk);
      if (ea < 0 && boot_done[0] === 1'b1) ea = e;
      if (eb < 0 && boot_done[1] === 1'b1) eb = e;
    end
    #1;
  endtask

  task automatic randomize_roms();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i <= plen(d); i++) rom[d][i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) rom[d][plen(d)] = csum(d);
    end
  endtask

  initial begin
    int ea, eb, wa, wb, r;
    logic [7:0] exp4[4];
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;

    rst_n = 1'b0; reboot = 1'b0;
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) begin rom[d][i] = 8'h00; ram[d][i] = 8'h00; end
    for (int i = 0; i < 4; i++) rom[0][i] = exp4[i];
    rom[0][4] = 8'hAA;
    rom[1][0] = 8'h5A; rom[1][1] = 8'h5A;

    repeat (3) step();
    wa = wr_cnt[0]; wb = wr_cnt[1];
    rst_n = 1'b1;
    wait_done(ea, eb);
    chk("lat_basic", 0, ea, CKS ? 9 : 8);
    chk("lat_single", 1, eb, CKS ? 3 : 2);
    for (int i = 0; i < 4; i++) chk("ram_basic", 0, ram[0][i], exp4[i]);
    chk("ram_single", 1, ram[1][0], 8'h5A);
    chk("wr_pulses", 0, wr_cnt[0] - wa, 4);
    chk("wr_pulses", 1, wr_cnt[1] - wb, 1);
    chk("err_match", 0, boot_err[0], 0);

    // Reboot in DONE with a bad checksum word, plus an ignored mid-copy pulse.
    rom[0][4] = 8'hAB;
    for (int i = 0; i < 4; i++) ram[0][i] = 8'h00;
    reboot = 1'b1;
    @(negedge clk);
    chk("done_drop", 0, boot_done[0], 0);
    #1 reboot = 1'b0;
    step();
    reboot = 1'b1;
    step();
    reboot = 1'b0;
    wait_done(ea, eb);
    chk("lat_reboot", 0, ea, CKS ? 7 : 6);
    for (int i = 0; i < 4; i++) chk("ram_rewrite", 0, ram[0][i], exp4[i]);
    chk("err_mismatch", 0, boot_err[0], CKS ? 1 : 0);
    chk("done_after_err", 0, boot_done[0], 1);

    // Reset just after word 2 is written.
    reboot = 1'b1;
    step();
    reboot = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    wait_done(ea, eb);
    chk("lat_after_rst", 0, ea, CKS ? 9 : 8);
    chk("lat_after_rst", 1, eb, CKS ? 3 : 2);

    // Random phase: reboots anywhere, occasional resets, fresh ROM images.
    for (int k = 0; k < 400; k++) begin
      reboot = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n = 1'b0;
        randomize_roms();
        repeat ($urandom_range(1, 2)) step();
        rst_n = 1'b1;
      end else if (r < 20) begin
        reboot = 1'b1;
      end else if (r < 30 && boot_done[0] === 1'b1 && boot_done[1] === 1'b1) begin
        randomize_roms();
      end
      step();
    end
    reboot = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
